// File: rtl/sn76489_register_decoder_if.sv
// Host write bus plus decoded control-register outputs of the SN76489 write port.
interface sn76489_register_decoder_if;
  logic [7:0]  data_in;
  logic        write_strobe;
  logic        ready;
  logic        overrun;
  logic [15:0] attn;
  logic [29:0] tone_freq;
  logic [2:0]  noise_ctrl;
  logic        reset_lfsr;

  modport master (
    output data_in, write_strobe,
    input  ready, overrun, attn, tone_freq, noise_ctrl, reset_lfsr
  );

  modport slave (
    input  data_in, write_strobe,
    output ready, overrun, attn, tone_freq, noise_ctrl, reset_lfsr
  );
endinterface

// File: rtl/sn76489_register_decoder.sv
// SN76489 CPU write port: decodes latch/data bytes into attenuation, tone and
// noise registers, with a READY busy window and a sticky overrun flag.
module sn76489_register_decoder #(
  parameter int WRITE_BUSY_CYCLES = 32,
  parameter int BUSY_COUNTER_BITS = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  sn76489_register_decoder_if.slave   bus
);

  localparam logic [BUSY_COUNTER_BITS-1:0] BUSY_LOAD = BUSY_COUNTER_BITS'(WRITE_BUSY_CYCLES);
  localparam logic [BUSY_COUNTER_BITS-1:0] BUSY_ONE  = BUSY_COUNTER_BITS'(1);
  localparam logic [BUSY_COUNTER_BITS-1:0] BUSY_ZERO = BUSY_COUNTER_BITS'(0);

  logic [15:0]                  attn_r, attn_s;
  logic [29:0]                  tone_r, tone_s;
  logic [2:0]                   noise_r, noise_s;
  logic [1:0]                   latch_ch_r, latch_ch_s;
  logic                         latch_type_r, latch_type_s;
  logic [BUSY_COUNTER_BITS-1:0] busy_r, busy_s;
  logic                         ready_r, ready_s;
  logic                         overrun_r, overrun_s;
  logic                         lfsr_r, lfsr_s;
  logic                         strobe_prev_r;
  logic                         accept_s;
  logic [1:0]                   ch_s;
  logic                         type_s;

  assign accept_s = bus.write_strobe & ready_r;

  // Target register: a latch byte names it, a data byte reuses the latched one.
  always_comb begin
    ch_s   = latch_ch_r;
    type_s = latch_type_r;
    if (bus.data_in[7]) begin
      ch_s   = bus.data_in[6:5];
      type_s = bus.data_in[4];
    end else begin
      ch_s   = latch_ch_r;
      type_s = latch_type_r;
    end
  end

  // Register-file update for an accepted byte.
  always_comb begin
    attn_s       = attn_r;
    tone_s       = tone_r;
    noise_s      = noise_r;
    latch_ch_s   = latch_ch_r;
    latch_type_s = latch_type_r;
    lfsr_s       = 1'b0;
    if (accept_s) begin
      if (bus.data_in[7]) begin
        latch_ch_s   = ch_s;
        latch_type_s = type_s;
      end else begin
        latch_ch_s   = latch_ch_r;
        latch_type_s = latch_type_r;
      end
      if (type_s) begin
        case (ch_s)
          2'd0:    attn_s[3:0]   = bus.data_in[3:0];
          2'd1:    attn_s[7:4]   = bus.data_in[3:0];
          2'd2:    attn_s[11:8]  = bus.data_in[3:0];
          2'd3:    attn_s[15:12] = bus.data_in[3:0];
          default: attn_s        = attn_r;
        endcase
      end else if (ch_s == 2'd3) begin
        noise_s = bus.data_in[2:0];
        lfsr_s  = 1'b1;
      end else begin
        // Latch bytes carry the low nibble of a period, data bytes the upper six bits.
        case (ch_s)
          2'd0: begin
            if (bus.data_in[7]) tone_s[3:0]   = bus.data_in[3:0];
            else                tone_s[9:4]   = bus.data_in[5:0];
          end
          2'd1: begin
            if (bus.data_in[7]) tone_s[13:10] = bus.data_in[3:0];
            else                tone_s[19:14] = bus.data_in[5:0];
          end
          2'd2: begin
            if (bus.data_in[7]) tone_s[23:20] = bus.data_in[3:0];
            else                tone_s[29:24] = bus.data_in[5:0];
          end
          default: tone_s = tone_r;
        endcase
      end
    end else begin
      lfsr_s = 1'b0;
    end
  end

  // Busy window and overrun; a strobe held since its own accept is not an overrun.
  always_comb begin
    busy_s    = busy_r;
    overrun_s = overrun_r;
    if (accept_s) begin
      busy_s = BUSY_LOAD;
    end else if (busy_r != BUSY_ZERO) begin
      busy_s = busy_r - BUSY_ONE;
    end else begin
      busy_s = busy_r;
    end
    if (bus.write_strobe && !ready_r && !strobe_prev_r) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end
    ready_s = (busy_s == BUSY_ZERO);
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attn_r        <= 16'hFFFF;
      tone_r        <= 30'd0;
      noise_r       <= 3'd0;
      latch_ch_r    <= 2'd0;
      latch_type_r  <= 1'b0;
      busy_r        <= BUSY_ZERO;
      ready_r       <= 1'b1;
      overrun_r     <= 1'b0;
      lfsr_r        <= 1'b0;
      strobe_prev_r <= 1'b0;
    end else begin
      attn_r        <= attn_s;
      tone_r        <= tone_s;
      noise_r       <= noise_s;
      latch_ch_r    <= latch_ch_s;
      latch_type_r  <= latch_type_s;
      busy_r        <= busy_s;
      ready_r       <= ready_s;
      overrun_r     <= overrun_s;
      lfsr_r        <= lfsr_s;
      strobe_prev_r <= bus.write_strobe;
    end
  end

  assign bus.attn       = attn_r;
  assign bus.tone_freq  = tone_r;
  assign bus.noise_ctrl = noise_r;
  assign bus.ready      = ready_r;
  assign bus.overrun    = overrun_r;
  assign bus.reset_lfsr = lfsr_r;

endmodule

// File: tb/tb_sn76489_register_decoder.sv
// Bench: three decoders (busy 32, 0, 4) share one random/directed byte stream
// and are compared every cycle against an array-based register model.
module tb_sn76489_register_decoder;
  localparam int NI = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] d_drv  = 8'h00;
  logic       ws_drv = 1'b0;

  logic [15:0] attn_o    [NI];
  logic [29:0] tone_o    [NI];
  logic [2:0]  noise_o   [NI];
  logic        ready_o   [NI];
  logic        overrun_o [NI];
  logic        lfsr_o    [NI];

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;
  int cyc      = 0;
  int nbusy [NI] = '{32, 0, 4};

  // Model state: per instance register arrays plus cycle of the last accept.
  logic [3:0] m_attn  [NI][4];
  logic [9:0] m_tone  [NI][3];
  logic [2:0] m_noise [NI];
  logic [1:0] m_lch   [NI];
  logic       m_lty   [NI];
  int         m_last  [NI];
  bit         m_over  [NI];
  bit         m_lfsr  [NI];
  bit         m_prev_ws;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : inst
    sn76489_register_decoder_if bus ();
    assign bus.data_in      = d_drv;
    assign bus.write_strobe = ws_drv;
    assign attn_o[g]    = bus.attn;
    assign tone_o[g]    = bus.tone_freq;
    assign noise_o[g]   = bus.noise_ctrl;
    assign ready_o[g]   = bus.ready;
    assign overrun_o[g] = bus.overrun;
    assign lfsr_o[g]    = bus.reset_lfsr;
    sn76489_register_decoder #(
      .WRITE_BUSY_CYCLES ((g == 0) ? 32 : ((g == 1) ? 0 : 4)),
      .BUSY_COUNTER_BITS (6)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) m_attn[k][c] = 4'hF;
      for (int c = 0; c < 3; c++) m_tone[k][c] = 10'd0;
      m_noise[k] = 3'd0;
      m_lch[k]   = 2'd0;
      m_lty[k]   = 1'b0;
      m_last[k]  = -1000;
      m_over[k]  = 1'b0;
      m_lfsr[k]  = 1'b0;
    end
    m_prev_ws = 1'b0;
  endtask

  function automatic bit m_ready(input int k, input int at_cycle);
    return (at_cycle - m_last[k]) >= nbusy[k];
  endfunction

  // Apply one clock edge (already counted in cyc) to the model.
  task automatic model_edge(input logic ws, input logic [7:0] d);
    logic [1:0] ch;
    logic       ty;
    for (int k = 0; k < NI; k++) begin
      m_lfsr[k] = 1'b0;
      if (ws && m_ready(k, cyc - 1)) begin
        m_last[k] = cyc;
        if (d[7]) begin
          m_lch[k] = d[6:5];
          m_lty[k] = d[4];
        end
        ch = m_lch[k];
        ty = m_lty[k];
        if (ty) m_attn[k][ch] = d[3:0];
        else if (ch == 2'd3) begin
          m_noise[k] = d[2:0];
          m_lfsr[k]  = 1'b1;
        end
        else if (d[7]) m_tone[k][ch][3:0] = d[3:0];
        else           m_tone[k][ch][9:4] = d[5:0];
      end else if (ws && !m_prev_ws) begin
        m_over[k] = 1'b1;
      end
    end
    m_prev_ws = ws;
  endtask

  task automatic step(input logic ws, input logic [7:0] d);
    ws_drv = ws;
    d_drv  = d;
    @(posedge clk);
    cyc++;
    model_edge(ws, d);
    @(negedge clk);
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!ready_o[k] && n < 100) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk($sformatf("wait_ready%0d", k), 32'(ready_o[k]), 32'd1);
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("attn%0d", k), 32'(attn_o[k]),
          32'({m_attn[k][3], m_attn[k][2], m_attn[k][1], m_attn[k][0]}));
      chk($sformatf("tone%0d", k), 32'(tone_o[k]),
          32'({m_tone[k][2], m_tone[k][1], m_tone[k][0]}));
      chk($sformatf("noise%0d", k), 32'(noise_o[k]), 32'(m_noise[k]));
      chk($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(m_ready(k, cyc)));
      chk($sformatf("overrun%0d", k), 32'(overrun_o[k]), 32'(m_over[k]));
      chk($sformatf("reset_lfsr%0d", k), 32'(lfsr_o[k]), 32'(m_lfsr[k]));
    end
  endtask

  // Compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (run && !reset) compare_all();
    end
  end

  initial begin
    int n;
    int hi;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_attn%0d", k), 32'(attn_o[k]), 32'h0000FFFF);
      chk($sformatf("rst_tone%0d", k), 32'(tone_o[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(ready_o[k]), 32'd1);
      chk($sformatf("rst_overrun%0d", k), 32'(overrun_o[k]), 32'd0);
    end

    // Tone 0 period via latch+data, with a fresh strobe landing in the busy window.
    step(1'b1, 8'h8E);
    step(1'b0, 8'h00);
    step(1'b1, 8'h0F);
    chk("n0_tone1_after_0F", 32'(tone_o[1][9:0]), 32'h0FE);
    wait_ready(0);
    step(1'b1, 8'h0F);
    n = 0;
    while (!ready_o[0] && n < 100) begin
      n++;
      step(1'b0, 8'h00);
    end
    chk("busy_len32", 32'(n), 32'd32);
    chk("tone0_0FE", 32'(tone_o[0][9:0]), 32'h0FE);
    chk("model_tone0_0FE", 32'(m_tone[0][0]), 32'h0FE);
    chk("overrun0_set", 32'(overrun_o[0]), 32'd1);

    // Back-to-back on the zero-busy instance.
    step(1'b1, 8'hBF);
    chk("n0_attn1_F", 32'(attn_o[1][7:4]), 32'hF);
    step(1'b1, 8'h05);
    chk("n0_attn1_5", 32'(attn_o[1][7:4]), 32'h5);
    step(1'b1, 8'hC3);
    step(1'b1, 8'h12);
    chk("n0_tone2_123", 32'(tone_o[1][29:20]), 32'h123);
    step(1'b0, 8'h00);

    // Noise writes pulse reset_lfsr.
    wait_ready(0);
    step(1'b1, 8'hE5);
    chk("noise_101", 32'(noise_o[0]), 32'h5);
    chk("lfsr_pulse1", 32'(lfsr_o[0]), 32'd1);
    step(1'b0, 8'h00);
    chk("lfsr_low", 32'(lfsr_o[0]), 32'd0);
    wait_ready(0);
    step(1'b1, 8'h02);
    chk("noise_010", 32'(noise_o[0]), 32'h2);
    chk("lfsr_pulse2", 32'(lfsr_o[0]), 32'd1);
    chk("attn0_kept", 32'(attn_o[0]), 32'h0000FFFF);
    chk("tone0_kept", 32'(tone_o[0]), 32'h0FE);
    step(1'b0, 8'h00);

    // Asynchronous reset with the busy counter at 17.
    wait_ready(0);
    step(1'b1, 8'h9A);
    repeat (15) step(1'b0, 8'h00);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_ready", 32'(ready_o[0]), 32'd1);
    chk("midrst_attn", 32'(attn_o[0]), 32'h0000FFFF);
    chk("midrst_tone", 32'(tone_o[0]), 32'd0);
    chk("midrst_noise", 32'(noise_o[0]), 32'd0);
    chk("midrst_overrun", 32'(overrun_o[0]), 32'd0);
    #1 reset = 1'b0;
    step(1'b1, 8'hD3);
    chk("post_rst_attn", 32'(attn_o[0]), 32'h0000F3FF);
    chk("post_rst_busy", 32'(ready_o[0]), 32'd0);
    step(1'b0, 8'h00);
    repeat (10) step(1'b0, 8'h00);

    // Held strobe on the 4-cycle-busy instance.
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h9A);
      if (ready_o[2]) hi++;
    end
    chk("held_accepts", 32'(hi), 32'd4);
    chk("held_attn2", 32'(attn_o[2][3:0]), 32'hA);
    chk("held_overrun2", 32'(overrun_o[2]), 32'd0);
    step(1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    step(1'b0, 8'h00);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
